mips_register_file_gen: RTL
===========================

MIPS_REGISTER_FILE_GEN -- requirements
Module: mips_register_file_gen

Interface
REQ-001 Parameter AWL, default 5, address word length; depth is 2^AWL entries.
REQ-002 Parameter DWL, default 32, data word length; an even value of at least 2.
REQ-003 Parameter NRP, default 2, number of asynchronous read ports; range 1 to 4.
REQ-004 Parameter ZERO_REG, default 1; when 1, address 0 reads as zero and ignores writes.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous reset, active low.
REQ-008 wen  input  1  write enable for WD at WA.
REQ-009 WA  input  AWL  write address.
REQ-010 WD  input  DWL  write data.
REQ-011 clr  input  1  synchronous request to zero the whole file.
REQ-012 RA  input  NRP*AWL  read addresses; port p uses bits [p*AWL +: AWL].
REQ-013 RD  output  NRP*DWL  read data; port p uses bits [p*DWL +: DWL].
REQ-014 busy  output  1  high while the clear sequencer owns the storage.

Function
REQ-015 Storage SHALL be 2^AWL x DWL, written synchronously and read combinationally on every port.
REQ-016 FSM SHALL have two states:
- CLEAR: counter ccnt writes zero to entry ccnt, one entry per cycle.
- IDLE: normal operation.
REQ-017 CLEAR SHALL go to IDLE on the edge that writes entry 2^AWL-1; ccnt returns to 0 on that edge.
REQ-018 IDLE with clr=1 SHALL go to CLEAR on the next edge with ccnt=0.
REQ-019 busy SHALL be 1 in CLEAR and 0 in IDLE; clear latency is exactly 2^AWL cycles.
REQ-020 In CLEAR, wen SHALL be ignored, and clr SHALL be ignored without restarting ccnt.
REQ-021 In CLEAR, every RD port SHALL output zero.
REQ-022 In IDLE, wen=1 SHALL write WD to WA on the edge, unless ZERO_REG=1 and WA=0.
REQ-023 In IDLE, if clr=1 and wen=1 in the same cycle, clr wins and the write is discarded.
REQ-024 In IDLE, each RD port SHALL present the stored entry at its RA, or zero when ZERO_REG=1 and RA=0.
REQ-025 Multiple read ports addressing the same entry SHALL all return identical data.

Reset
REQ-026 rst_n low SHALL immediately force state CLEAR, ccnt=0, busy=1 and all RD to zero.
REQ-027 After rst_n rises, the first rising clk edge SHALL clear entry 0; busy falls after 2^AWL edges.
REQ-028 Reset asserted mid-clear or mid-operation SHALL restart the clear from entry 0.
REQ-029 Storage contents SHALL NOT depend on the reset net; zeroing is done only by the sequencer.

Configuration
REQ-030 The compile macro SHALL be REGFILE_BYPASS_EN.
REQ-031 When REGFILE_BYPASS_EN is defined, in IDLE with wen=1 and RA=WA, RD SHALL return WD combinationally (write-first).
- Exception: when ZERO_REG=1 and WA=0, RD stays zero.
REQ-032 When REGFILE_BYPASS_EN is not defined, RD SHALL return the pre-write contents until the next edge (read-first).

Verification
REQ-033 Reset and clear: pulse rst_n low, then release -> busy=1 for exactly 32 edges (AWL=5), then 0; all 32 entries read 0x00000000 on both ports.
REQ-034 Write/read: write 0xDEADBEEF to 7 and 0x12345678 to 31; RA0=7, RA1=31 -> RD0=0xDEADBEEF, RD1=0x12345678.
REQ-035 Zero register: with ZERO_REG=1, write 0xFFFFFFFF to 0 -> RA=0 returns 0x00000000 on all ports.
REQ-036 Clear collision: in IDLE, clr=1 with wen=1, WA=3, WD=0xA5A5A5A5 -> busy rises next edge; after 32 cycles entry 3 reads 0.
REQ-037 Bypass: entry 9 holds 0x11111111; write 0x22222222 to 9 with RA0=9 before the edge:
- with REGFILE_BYPASS_EN, RD0=0x22222222;
- without it, RD0=0x11111111, and 0x22222222 after the edge.
REQ-038 Reset mid-clear: assert rst_n low at ccnt=10 -> after release, busy stays high for a full 32 edges.

Source files
------------

// File: rtl/mips_register_file_gen.sv
// Multi-port register file with a self-clearing sequencer that zeroes every entry after reset or on clr.
// Optional macro REGFILE_BYPASS_EN: write-first read bypass. Without it, reads return the pre-write contents.
module mips_register_file_gen #(
  parameter int AWL      = 5,
  parameter int DWL      = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wen,
  input  logic [AWL-1:0]       WA,
  input  logic [DWL-1:0]       WD,
  input  logic                 clr,
  input  logic [NRP*AWL-1:0]   RA,
  output logic [NRP*DWL-1:0]   RD,
  output logic                 busy
);

  localparam int DEPTH = 1 << AWL;
  localparam logic [AWL-1:0] LAST_ADDR = {AWL{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [AWL-1:0] ccnt_q, ccnt_d;

  logic [DWL-1:0] mem_q [DEPTH];
  logic           mem_we;
  logic [AWL-1:0] mem_wa;
  logic [DWL-1:0] mem_wd;

  logic wa_is_zero_reg;
  assign wa_is_zero_reg = (ZERO_REG != 0) && (WA == '0);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ccnt_d  = ccnt_q;
    mem_we  = 1'b0;
    mem_wa  = WA;
    mem_wd  = WD;
    unique case (state_q)
      ST_CLEAR: begin
        // The sequencer owns the write port; wen and clr are ignored here.
        mem_we = 1'b1;
        mem_wa = ccnt_q;
        mem_wd = '0;
        if (ccnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ccnt_d  = '0;
        end else begin
          ccnt_d = ccnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          ccnt_d  = '0;
        end else if (wen && !wa_is_zero_reg) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ccnt_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ccnt_q  <= ccnt_d;
    end
  end

  // NOTE: storage has no reset; the clear sequencer zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    RD = '0;
    if (state_q == ST_IDLE) begin
      for (int p = 0; p < NRP; p++) begin
        if (!((ZERO_REG != 0) && (RA[p*AWL +: AWL] == '0))) begin
          RD[p*DWL +: DWL] = mem_q[RA[p*AWL +: AWL]];
`ifdef REGFILE_BYPASS_EN
          // mem_we in IDLE already excludes clr collisions and the zero register.
          if (mem_we && (RA[p*AWL +: AWL] == WA)) begin
            RD[p*DWL +: DWL] = WD;
          end
`endif
        end
      end
    end
  end

endmodule
